// File: rtl/ada4355_frame_align.sv
// ADA4355 frame-clock alignment: finds the SERDES bit-slip that yields FRAME_PATTERN.
// Define ADA4355_FRAME_ALIGN_DIRECT_EN to jump straight to the observed rotation.
module ada4355_frame_align #(
    parameter logic [7:0] FRAME_PATTERN = 8'hF0,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 16,
    parameter int         MISS_LIMIT    = 4,
    parameter int         MAX_SWEEPS    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       align_en,
    input  logic [7:0] frame_data,
    input  logic       frame_valid,
    output logic [2:0] shift_cnt,
    output logic       shift_load,
    output logic       locked,
    output logic       align_fail,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        LOCKED,
        FAIL
    } state_t;

    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES);
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_LIMIT);
    localparam logic [6:0] TRY_LAST   = 7'(8 * MAX_SWEEPS);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [7:0] match_cnt;
    logic [7:0] miss_cnt;
    logic [6:0] try_cnt;

    logic       frame_hit;
    logic [7:0] match_nxt;
    logic [7:0] miss_nxt;
    logic [6:0] try_nxt;
    logic [2:0] rot_k;

    assign frame_hit = (frame_data == FRAME_PATTERN);
    assign match_nxt = match_cnt + 8'd1;
    assign miss_nxt  = miss_cnt + 8'd1;
    assign try_nxt   = try_cnt + 7'd1;

`ifdef ADA4355_FRAME_ALIGN_DIRECT_EN
    function automatic logic [7:0] rotl8(input logic [7:0] w, input logic [2:0] k);
        logic [15:0] d;
        d = {w, w} << k;
        return d[15:8];
    endfunction

    // Descending scan so the smallest matching k wins; 1 is the sweep fallback.
    always_comb begin
        rot_k = 3'd1;
        for (int k = 7; k >= 1; k--) begin
            if (rotl8(frame_data, 3'(k)) == FRAME_PATTERN) begin
                rot_k = 3'(k);
            end
        end
    end
`else
    assign rot_k = 3'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shift_cnt     <= 3'd0;
            shift_load    <= 1'b0;
            locked        <= 1'b0;
            align_fail    <= 1'b0;
            lock_lost_cnt <= 8'd0;
            settle_cnt    <= 4'd0;
            match_cnt     <= 8'd0;
            miss_cnt      <= 8'd0;
            try_cnt       <= 7'd0;
        end else begin
            shift_load <= 1'b0;
            if (!align_en) begin
                state      <= IDLE;
                locked     <= 1'b0;
                align_fail <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        try_cnt <= 7'd0;
                        state   <= APPLY;
                    end
                    APPLY: begin
                        shift_load <= 1'b1;
                        settle_cnt <= SETTLE_LD;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt <= 4'd1) begin
                            match_cnt <= 8'd0;
                            state     <= CHECK;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    CHECK: begin
                        if (frame_valid) begin
                            if (frame_hit) begin
                                match_cnt <= match_nxt;
                                if (match_nxt == MATCH_LAST) begin
                                    locked   <= 1'b1;
                                    miss_cnt <= 8'd0;
                                    state    <= LOCKED;
                                end
                            end else begin
                                shift_cnt <= shift_cnt + rot_k;
                                try_cnt   <= try_nxt;
                                if (try_nxt == TRY_LAST) begin
                                    align_fail <= 1'b1;
                                    state      <= FAIL;
                                end else begin
                                    state <= APPLY;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (frame_valid) begin
                            if (frame_hit) begin
                                miss_cnt <= 8'd0;
                            end else if (miss_nxt == MISS_LAST) begin
                                locked   <= 1'b0;
                                miss_cnt <= 8'd0;
                                try_cnt  <= 7'd0;
                                state    <= APPLY;
                                if (lock_lost_cnt != 8'hFF) begin
                                    lock_lost_cnt <= lock_lost_cnt + 8'd1;
                                end
                            end else begin
                                miss_cnt <= miss_nxt;
                            end
                        end
                    end
                    FAIL: begin
                        align_fail <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ada4355_frame_align.sv
// Directed bench for ada4355_frame_align with a bit-slip SERDES model.
// Expectations follow ADA4355_FRAME_ALIGN_DIRECT_EN when it is defined.
module tb_ada4355_frame_align;

    localparam logic [7:0] PAT = 8'hF0;

    logic       clk = 1'b0;
    logic       rst;
    logic       align_en;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic [2:0] shift_cnt;
    logic       shift_load;
    logic       locked;
    logic       align_fail;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] raw;
    logic [2:0] serdes_shift;

    ada4355_frame_align dut (
        .clk           (clk),
        .rst           (rst),
        .align_en      (align_en),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .shift_cnt     (shift_cnt),
        .shift_load    (shift_load),
        .locked        (locked),
        .align_fail    (align_fail),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #4 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int k);
        logic [15:0] d;
        d = {w, w} << k;
        return d[15:8];
    endfunction

    // One clock; sample 1 ns after the edge, then present the next word.
    task automatic step();
        @(posedge clk);
        #1;
        if (shift_load) serdes_shift = shift_cnt;
        frame_data = rotl8(raw, int'(serdes_shift));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        align_en = 1'b0;
        frame_valid = 1'b1;
        serdes_shift = 3'd0;
        frame_data = rotl8(raw, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        raw = PAT;
        do_reset();
        checks++;
        if (shift_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_shift_cnt got=%0d exp=0", shift_cnt);
        end
        checks++;
        if (shift_load !== 1'b0) begin
            failures++;
            $display("FAIL reset_shift_load got=%b exp=0", shift_load);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_locked got=%b exp=0", locked);
        end
        checks++;
        if (align_fail !== 1'b0) begin
            failures++;
            $display("FAIL reset_align_fail got=%b exp=0", align_fail);
        end
        checks++;
        if (lock_lost_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_lock_lost got=%0d exp=0", lock_lost_cnt);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (shift_load === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL idle_no_pulse got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_aligned();
        int pulses;
        int pulse_at;
        logic [2:0] pulse_val;
        logic l21;
        logic l22;
        raw = PAT;
        do_reset();
        align_en = 1'b1;
        pulses = 0;
        pulse_at = -1;
        pulse_val = 3'd7;
        l21 = 1'bx;
        l22 = 1'bx;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (shift_load === 1'b1) begin
                pulses++;
                pulse_at = i;
                pulse_val = shift_cnt;
            end
            if (i == 21) l21 = locked;
            if (i == 22) l22 = locked;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL aligned_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (pulse_at != 2) begin
            failures++;
            $display("FAIL aligned_pulse_cycle got=%0d exp=2", pulse_at);
        end
        checks++;
        if (pulse_val !== 3'd0) begin
            failures++;
            $display("FAIL aligned_pulse_shift got=%0d exp=0", pulse_val);
        end
        checks++;
        if (l21 !== 1'b0) begin
            failures++;
            $display("FAIL aligned_early_lock got=%b exp=0", l21);
        end
        checks++;
        if (l22 !== 1'b1) begin
            failures++;
            $display("FAIL aligned_lock got=%b exp=1", l22);
        end
    endtask

    task automatic test_en_drop();
        raw = PAT;
        do_reset();
        align_en = 1'b1;
        for (int i = 1; i <= 21; i++) step();
        align_en = 1'b0;
        step();
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_lock got=%b exp=0", locked);
        end
        step();
        checks++;
        if (locked !== 1'b0 || shift_load !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_idle got=%b%b exp=00", locked, shift_load);
        end
    endtask

    task automatic test_sweep();
        logic [2:0] vals[8];
        logic [2:0] expv[6];
        int exp_n;
        int np;
        int last_at;
        int lock_at;
`ifdef ADA4355_FRAME_ALIGN_DIRECT_EN
        expv = '{3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_n = 2;
`else
        expv = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        exp_n = 6;
`endif
        raw = 8'h87;
        do_reset();
        align_en = 1'b1;
        np = 0;
        last_at = -100;
        lock_at = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (shift_load === 1'b1) begin
                if (np < 8) vals[np] = shift_cnt;
                np++;
                last_at = i;
            end
            if (locked === 1'b1) begin
                lock_at = i;
                break;
            end
        end
        checks++;
        if (np != exp_n) begin
            failures++;
            $display("FAIL sweep_pulses got=%0d exp=%0d", np, exp_n);
        end
        for (int j = 0; j < exp_n; j++) begin
            if (j < np && j < 8) begin
                checks++;
                if (vals[j] !== expv[j]) begin
                    failures++;
                    $display("FAIL sweep_step%0d got=%0d exp=%0d", j, vals[j], expv[j]);
                end
            end
        end
        checks++;
        if (locked !== 1'b1 || shift_cnt !== 3'd5) begin
            failures++;
            $display("FAIL sweep_lock got=%b/%0d exp=1/5", locked, shift_cnt);
        end
        checks++;
        if (lock_at != last_at + 20) begin
            failures++;
            $display("FAIL sweep_lock_cycle got=%0d exp=%0d", lock_at, last_at + 20);
        end
    endtask

    task automatic test_reenable_rst();
        int pulses;
        align_en = 1'b0;
        step();
        checks++;
        if (locked !== 1'b0 || shift_cnt !== 3'd5) begin
            failures++;
            $display("FAIL disable_retain got=%b/%0d exp=0/5", locked, shift_cnt);
        end
        align_en = 1'b1;
        step();
        step();
        checks++;
        if (shift_load !== 1'b1 || shift_cnt !== 3'd5) begin
            failures++;
            $display("FAIL reenable_pulse got=%b/%0d exp=1/5", shift_load, shift_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (shift_load !== 1'b0 || shift_cnt !== 3'd0 || locked !== 1'b0
            || align_fail !== 1'b0 || lock_lost_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_rst got=%b/%0d/%b/%b/%0d exp=0/0/0/0/0",
                     shift_load, shift_cnt, locked, align_fail, lock_lost_cnt);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (shift_load === 1'b1) pulses++;
        end
        align_en = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (shift_load === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL rst_no_pulse got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_fail();
        int pulses;
        int fail_at;
        int extra;
        raw = 8'h00;
        do_reset();
        align_en = 1'b1;
        pulses = 0;
        fail_at = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (shift_load === 1'b1) pulses++;
            if (align_fail === 1'b1) begin
                fail_at = i;
                break;
            end
        end
        checks++;
        if (pulses != 16) begin
            failures++;
            $display("FAIL fail_tries got=%0d exp=16", pulses);
        end
        checks++;
        if (fail_at != 97) begin
            failures++;
            $display("FAIL fail_cycle got=%0d exp=97", fail_at);
        end
        checks++;
        if (shift_cnt !== 3'd0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL fail_wrap got=%0d/%b exp=0/0", shift_cnt, locked);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (shift_load === 1'b1) extra++;
        end
        checks++;
        if (align_fail !== 1'b1 || extra != 0) begin
            failures++;
            $display("FAIL fail_hold got=%b/%0d exp=1/0", align_fail, extra);
        end
        align_en = 1'b0;
        step();
        checks++;
        if (align_fail !== 1'b0 || shift_cnt !== 3'd0) begin
            failures++;
            $display("FAIL fail_clear got=%b/%0d exp=0/0", align_fail, shift_cnt);
        end
    endtask

    task automatic test_lock_loss();
        raw = 8'h3C;
        do_reset();
        align_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (locked === 1'b1) break;
        end
        checks++;
        if (locked !== 1'b1 || shift_cnt !== 3'd2) begin
            failures++;
            $display("FAIL loss_initial got=%b/%0d exp=1/2", locked, shift_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            frame_data = 8'h00;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            frame_valid = 1'b0;
            frame_data = 8'h00;
            step();
        end
        frame_valid = 1'b1;
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_3bad got=%b exp=1", locked);
        end
        step();
        checks++;
        if (locked !== 1'b1 || lock_lost_cnt !== 8'd0) begin
            failures++;
            $display("FAIL loss_good got=%b/%0d exp=1/0", locked, lock_lost_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            frame_data = 8'h00;
            step();
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_3of4 got=%b exp=1", locked);
        end
        frame_data = 8'h00;
        step();
        checks++;
        if (locked !== 1'b0 || lock_lost_cnt !== 8'd1) begin
            failures++;
            $display("FAIL loss_drop got=%b/%0d exp=0/1", locked, lock_lost_cnt);
        end
        step();
        checks++;
        if (shift_load !== 1'b1 || shift_cnt !== 3'd2) begin
            failures++;
            $display("FAIL loss_reapply got=%b/%0d exp=1/2", shift_load, shift_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if (locked === 1'b1) break;
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_relock got=%b exp=1", locked);
        end
    endtask

    task automatic test_saturate();
        raw = PAT;
        do_reset();
        align_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 40; i++) begin
                step();
                if (locked === 1'b1) break;
            end
            if (locked !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL sat_relock_timeout iter=%0d got=%b exp=1", n, locked);
                break;
            end
            for (int i = 0; i < 4; i++) begin
                frame_data = 8'h00;
                step();
            end
            if (n == 253) begin
                checks++;
                if (lock_lost_cnt !== 8'd254) begin
                    failures++;
                    $display("FAIL sat_254 got=%0d exp=254", lock_lost_cnt);
                end
            end
        end
        checks++;
        if (lock_lost_cnt !== 8'd255 || locked !== 1'b0) begin
            failures++;
            $display("FAIL sat_255 got=%0d/%b exp=255/0", lock_lost_cnt, locked);
        end
    endtask

    initial begin
        rst = 1'b1;
        align_en = 1'b0;
        frame_valid = 1'b1;
        frame_data = 8'h00;
        raw = PAT;
        serdes_shift = 3'd0;
        test_reset();
        test_aligned();
        test_en_drop();
        test_sweep();
        test_reenable_rst();
        test_fail();
        test_lock_loss();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ada4355_frame_align.md
# ada4355_frame_align

Frame-alignment controller for the ADA4355 LVDS receive path. It watches the 8-bit frame-clock word produced by the frame SERDES every `clk` cycle. It sweeps, or directly computes, the bit-slip value `shift_cnt` that the data and frame SERDES apply, until the captured frame word equals the expected pattern. Once locked it monitors the pattern continuously and re-aligns on loss of lock. It sits between the frame deserializer and the ADC core's shift register in the 125 MHz ADC clock domain.

## Interface
Parameters:
- `FRAME_PATTERN`, 8'hF0, expected frame word when aligned; every rotation of it must be distinct.
- `SETTLE_CYCLES`, 4, `clk` cycles waited after each `shift_load` before checking (1..15).
- `MATCH_COUNT`, 16, consecutive matching valid words required to declare lock (1..255).
- `MISS_LIMIT`, 4, consecutive mismatching valid words in LOCKED that drop lock (1..255).
- `MAX_SWEEPS`, 2, full 8-position sweeps attempted before FAIL (1..15).

Ports:
- `clk` in 1: ADC frame-rate clock. It is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `align_en` in 1: level input. 1 runs alignment; 0 forces IDLE.
- `frame_data` in 8: deserialized frame word.
- `frame_valid` in 1: `frame_data` is valid this cycle.
- `shift_cnt` out 3: bit-slip value applied to all SERDES lanes.
- `shift_load` out 1: one-cycle pulse; the SERDES latches `shift_cnt`.
- `locked` out 1: alignment achieved and held.
- `align_fail` out 1: all sweeps exhausted without lock.
- `lock_lost_cnt` out 8: saturating count of LOCKED→APPLY transitions.

## Operation
- States are IDLE, APPLY, SETTLE, CHECK, LOCKED and FAIL.
- **IDLE:** if `align_en`=1, go to APPLY and clear the try counter.
- **APPLY:** assert `shift_load` for 1 cycle and load the settle counter. Next state is SETTLE.
- **SETTLE:** count `SETTLE_CYCLES` `clk` cycles, independent of `frame_valid`. Clear the match counter, then go to CHECK.
- **CHECK:** acts only on `frame_valid`=1 cycles.
  - `frame_data`==`FRAME_PATTERN`: increment the match counter. When the counter reaches `MATCH_COUNT`, go to LOCKED.
  - Mismatch: set `shift_cnt` ← (`shift_cnt`+1) mod 8 and increment the try counter.
  - If the try counter reaches 8·`MAX_SWEEPS`, go to FAIL. Otherwise go to APPLY.
- **LOCKED:** `locked`=1. Only `frame_valid` cycles count.
  - A mismatch increments the miss counter; a match clears it.
  - When the miss counter reaches `MISS_LIMIT`: `locked`←0, `lock_lost_cnt`++ (saturates at 255), try counter cleared, go to APPLY with `shift_cnt` unchanged.
- **FAIL:** `align_fail`=1. The block stays in FAIL until `align_en` is 0.
- `align_en`=0 in any state means IDLE next cycle, with `locked` and `align_fail` cleared.
  - `shift_cnt` and `lock_lost_cnt` are retained.
  - A later re-enable resumes the sweep from the retained `shift_cnt`.
- `shift_cnt` arithmetic is 3-bit, so 7+1 wraps to 0.
- If the match counter reaching `MATCH_COUNT` and `align_en` falling occur in the same cycle, `align_en` wins and the next state is IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - `shift_cnt`=0, `shift_load`=0, `locked`=0, `align_fail`=0, `lock_lost_cnt`=0.
  - All internal counters are 0.
- All outputs are registered. Input-to-output latency is 1 cycle.
- Sequence from `align_en` rising to the first check:
  - `align_en` rises (cycle N).
  - `shift_load` pulses in cycle N+2: IDLE→APPLY in N+1, pulse registered in N+2.
  - CHECK begins `SETTLE_CYCLES` after the pulse.
- `locked` rises 1 cycle after the `MATCH_COUNT`-th matching valid word.
- The new `shift_cnt` is stable on the cycle `shift_load` is high and is held until the next pulse.
- `rst` asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- `ADA4355_FRAME_ALIGN_DIRECT_EN` defined: on a CHECK mismatch, find the smallest k in 1..7 with rotate_left(`frame_data`,k)==`FRAME_PATTERN`.
  - If such a k exists: `shift_cnt` ← (`shift_cnt`+k) mod 8, and the try counter increments by 1.
  - If no k exists (corrupted word): fall back to the +1 sweep step.
- Undefined: only the +1 sweep is built, and the rotation-search logic is absent.

## Test plan
- Reset, `align_en`=1, pattern aligned at `shift_cnt`=0 → one `shift_load` with `shift_cnt`=0; `locked`=1 exactly 16 valid words after CHECK entry.
- Bench misaligned so alignment requires `shift_cnt`=5 (macro undefined) → `shift_load` pulses with `shift_cnt`=0,1,2,3,4,5; then lock.
  - Macro defined, same stimulus → `shift_cnt` goes 0→5 in a single step; lock after one settle and 16 matches.
- Constant `frame_data`=8'h00 → `align_fail`=1 after 16 tries.
  - `align_en`=0 clears `align_fail` next cycle; `shift_cnt`=0 after the wrap.
- In LOCKED: inject 3 bad words then 1 good → stays locked.
  - 4 consecutive bad words → `locked`=0, `lock_lost_cnt`=1, `shift_load` pulses with `shift_cnt` unchanged.
- Assert `rst` during SETTLE → outputs return to reset values immediately and `shift_load` does not pulse.
  - Force 300 lock losses → `lock_lost_cnt` saturates at 255.
